// File: rtl/cpu_seq_ctrl_if.sv
// Handshake and strobe bundle between the sequencing controller and the datapath/memories.
// The master side is the controller; the slave side is the datapath and memory models.
interface cpu_seq_ctrl_if;
    logic [6:0] opcode;
    logic       imem_ready;
    logic       dmem_ready;
    logic       branch_taken;
    logic       imem_req;
    logic       ir_en;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       pc_en;
    logic       pc_src;

    modport master (
        input  opcode, imem_ready, dmem_ready, branch_taken,
        output imem_req, ir_en, dmem_req, dmem_we, rf_we, wb_sel, pc_en, pc_src
    );

    modport slave (
        output opcode, imem_ready, dmem_ready, branch_taken,
        input  imem_req, ir_en, dmem_req, dmem_we, rf_we, wb_sel, pc_en, pc_src
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the RV32I core,
// with cycle and retired-instruction counters and a sticky HALT on SYSTEM/illegal opcodes.
module cpu_seq_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    cpu_seq_ctrl_if.master     bus,
    output logic [2:0]         state,
    output logic               halted,
    output logic               trap,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   instret_count
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CL_NONE, CL_LOAD, CL_STORE, CL_ALU, CL_JUMP, CL_BRANCH
    } cls_e;

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    logic             trap_q, trap_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] instret_count_q, instret_count_d;

    logic       imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en, pc_src;
    logic [1:0] wb_sel;

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        trap_d   = trap_q;
        imem_req = 1'b0;
        ir_en    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 2'd0;
        pc_en    = 1'b0;
        pc_src   = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_en   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
                case (bus.opcode)
                    7'b0000011: cls_d = CL_LOAD;
                    7'b0100011: cls_d = CL_STORE;
                    7'b0110011, 7'b0010011,
                    7'b0110111, 7'b0010111: cls_d = CL_ALU;
                    7'b1101111, 7'b1100111: cls_d = CL_JUMP;
                    7'b1100011: cls_d = CL_BRANCH;
                    7'b1110011: begin
                        cls_d   = CL_NONE;
                        state_d = S_HALT;
                    end
                    default: begin
                        cls_d   = CL_NONE;
                        state_d = S_HALT;
                        trap_d  = 1'b1;
                    end
                endcase
            end
            S_EXECUTE: begin
                if (cls_q == CL_BRANCH) begin
                    pc_en   = 1'b1;
                    pc_src  = bus.branch_taken;
                    state_d = S_FETCH;
                end else if (cls_q == CL_LOAD || cls_q == CL_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CL_STORE);
                if (bus.dmem_ready) begin
                    if (cls_q == CL_STORE) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                rf_we   = 1'b1;
                pc_en   = 1'b1;
                state_d = S_FETCH;
                if (cls_q == CL_LOAD) begin
                    wb_sel = 2'd1;
                end else if (cls_q == CL_JUMP) begin
                    wb_sel = 2'd2;
                    pc_src = 1'b1;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Reset overrides: the aborted instruction must not leave any strobe behind.
        if (reset) begin
            imem_req = 1'b0;
            ir_en    = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            rf_we    = 1'b0;
            wb_sel   = 2'd0;
            pc_en    = 1'b0;
            pc_src   = 1'b0;
        end

        cycle_count_d   = cycle_count_q + ((state_q != S_HALT) ? CNT_W'(1) : CNT_W'(0));
        instret_count_d = instret_count_q + (pc_en ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_FETCH;
            cls_q           <= CL_NONE;
            trap_q          <= 1'b0;
            cycle_count_q   <= '0;
            instret_count_q <= '0;
        end else begin
            state_q         <= state_d;
            cls_q           <= cls_d;
            trap_q          <= trap_d;
            cycle_count_q   <= cycle_count_d;
            instret_count_q <= instret_count_d;
        end
    end

    assign bus.imem_req   = imem_req;
    assign bus.ir_en      = ir_en;
    assign bus.dmem_req   = dmem_req;
    assign bus.dmem_we    = dmem_we;
    assign bus.rf_we      = rf_we;
    assign bus.wb_sel     = wb_sel;
    assign bus.pc_en      = pc_en;
    assign bus.pc_src     = pc_src;

    assign state          = state_q;
    assign halted         = (state_q == S_HALT);
    assign trap           = trap_q;
    assign cycle_count    = cycle_count_q;
    assign instret_count  = instret_count_q;
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge of the same cycle.
module tb_cpu_seq_ctrl;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic        clk;
    logic        reset;
    logic [2:0]  state;
    logic        halted;
    logic        trap;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;
    int          checks;
    int          failures;

    cpu_seq_ctrl_if bus ();

    cpu_seq_ctrl #(.CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.master),
        .state         (state),
        .halted        (halted),
        .trap          (trap),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    // Leaves the bench 1ns into cycle 1 after reset, state expected FETCH.
    task automatic do_reset();
        reset = 1'b1;
        nxt();
        nxt();
        reset = 1'b0;
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        bus.opcode       = OP_OP;
        bus.imem_ready   = 1'b1;
        bus.dmem_ready   = 1'b1;
        bus.branch_taken = 1'b1;

        // Strobes stay low while reset is held, even with ready inputs high
        nxt();
        nxt();
        half();
        chk("rst imem_req", bus.imem_req, 0);
        chk("rst ir_en", bus.ir_en, 0);
        chk("rst pc_en", bus.pc_en, 0);
        nxt();
        reset = 1'b0;
        half();
        chk("rst state", state, 0);
        chk("rst halted", halted, 0);
        chk("rst trap", trap, 0);
        chk("rst cycle", cycle_count, 0);
        chk("rst instret", instret_count, 0);
        chk("rst imem_req", bus.imem_req, 1);

        // Three back-to-back OP instructions, zero-wait memory
        do_reset();
        bus.opcode = OP_OP;
        bus.imem_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            half();
            chk($sformatf("op pc_en c%0d", c), bus.pc_en, (c % 4 == 0));
            chk($sformatf("op rf_we c%0d", c), bus.rf_we, (c % 4 == 0));
            nxt();
        end
        half();
        chk("op cycle", cycle_count, 12);
        chk("op instret", instret_count, 3);

        // BRANCH taken then BRANCH not taken
        do_reset();
        bus.opcode = OP_BRANCH;
        for (int c = 1; c <= 6; c++) begin
            bus.branch_taken = (c <= 3);
            half();
            chk($sformatf("br pc_en c%0d", c), bus.pc_en, (c == 3 || c == 6));
            chk($sformatf("br pc_src c%0d", c), bus.pc_src, (c == 3));
            chk($sformatf("br rf_we c%0d", c), bus.rf_we, 0);
            nxt();
        end
        half();
        chk("br instret", instret_count, 2);

        // LOAD with two data-memory wait cycles; dmem_ready high early must be ignored
        do_reset();
        bus.opcode = OP_LOAD;
        for (int c = 1; c <= 7; c++) begin
            bus.dmem_ready = !(c == 4 || c == 5);
            half();
            chk($sformatf("ld dmem_req c%0d", c), bus.dmem_req, (c >= 4 && c <= 6));
            chk($sformatf("ld dmem_we c%0d", c), bus.dmem_we, 0);
            chk($sformatf("ld rf_we c%0d", c), bus.rf_we, (c == 7));
            chk($sformatf("ld wb_sel c%0d", c), bus.wb_sel, (c == 7) ? 1 : 0);
            chk($sformatf("ld pc_en c%0d", c), bus.pc_en, (c == 7));
            nxt();
        end
        half();
        chk("ld state", state, 0);
        chk("ld cycle", cycle_count, 7);
        chk("ld instret", instret_count, 1);

        // STORE with three instruction-memory wait cycles
        do_reset();
        bus.opcode = OP_STORE;
        bus.dmem_ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            bus.imem_ready = (c >= 4);
            half();
            chk($sformatf("st imem_req c%0d", c), bus.imem_req, (c <= 4));
            chk($sformatf("st ir_en c%0d", c), bus.ir_en, (c == 4));
            chk($sformatf("st dmem_we c%0d", c), bus.dmem_we, (c == 7));
            chk($sformatf("st pc_en c%0d", c), bus.pc_en, (c == 7));
            chk($sformatf("st pc_src c%0d", c), bus.pc_src, 0);
            chk($sformatf("st rf_we c%0d", c), bus.rf_we, 0);
            nxt();
        end
        half();
        chk("st state", state, 0);
        chk("st cycle", cycle_count, 7);
        chk("st instret", instret_count, 1);

        // Illegal opcode halts with trap; then SYSTEM halts without trap
        for (int k = 0; k < 2; k++) begin
            do_reset();
            bus.opcode = (k == 0) ? 7'b0000000 : OP_SYSTEM;
            bus.imem_ready = 1'b1;
            for (int c = 1; c <= 6; c++) begin
                half();
                chk($sformatf("h%0d halted c%0d", k, c), halted, (c >= 3));
                chk($sformatf("h%0d imem_req c%0d", k, c), bus.imem_req, (c == 1));
                chk($sformatf("h%0d pc_en c%0d", k, c), bus.pc_en, 0);
                if (c >= 3) begin
                    chk($sformatf("h%0d state c%0d", k, c), state, 5);
                    chk($sformatf("h%0d trap c%0d", k, c), trap, (k == 0));
                    chk($sformatf("h%0d cycle c%0d", k, c), cycle_count, 2);
                    chk($sformatf("h%0d instret c%0d", k, c), instret_count, 0);
                end
                nxt();
            end
        end

        // JAL retires once, then a second JAL is aborted by reset in WRITEBACK
        do_reset();
        bus.opcode = OP_JAL;
        for (int c = 1; c <= 7; c++) begin
            half();
            if (c == 4) begin
                chk("jal wb_sel", bus.wb_sel, 2);
                chk("jal pc_src", bus.pc_src, 1);
                chk("jal rf_we", bus.rf_we, 1);
                chk("jal pc_en", bus.pc_en, 1);
            end
            nxt();
        end
        reset = 1'b1;
        half();
        chk("jalrst state", state, 4);
        chk("jalrst pc_en", bus.pc_en, 0);
        chk("jalrst rf_we", bus.rf_we, 0);
        chk("jalrst instret_before", instret_count, 1);
        nxt();
        reset = 1'b0;
        half();
        chk("jalrst state_after", state, 0);
        chk("jalrst cycle_after", cycle_count, 0);
        chk("jalrst instret_after", instret_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
